// File: rtl/feedback_packer.sv
// Packs IN_WIDTH result beats into DATA_WIDTH words for the feedback C2H FIFO,
// counting words per result set and pulsing process_done after the last write.
module feedback_packer #(
  parameter int TCQ        = 1,
  parameter int DATA_WIDTH = 128,
  parameter int IN_WIDTH   = 32
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  wr_en,
  output logic [31:0]           data_len,
  output logic                  process_done
);

  localparam int LANES = DATA_WIDTH / IN_WIDTH;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  // TCQ is kept for drop-in parameter compatibility; registers carry no delay.
  if ((DATA_WIDTH % IN_WIDTH) != 0 || LANES < 1 || TCQ < 0) begin : g_param_check
    $error("feedback_packer: DATA_WIDTH must be a positive multiple of IN_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        lane_cnt_q, lane_cnt_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    wr_en_q, wr_en_d;
  logic [31:0]             len_q, len_d;
  logic                    pd_q, pd_d;
  logic                    first_q, first_d;
  logic                    accept;
  logic                    lane_last;
  logic [DATA_WIDTH-1:0]   word;

  assign accept    = s_valid && s_ready;
  assign lane_last = (lane_cnt_q == CNT_W'(LANES - 1));

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, PACK: begin
        if (accept) begin
          if (s_last)         state_d = DONE;
          else if (lane_last) state_d = IDLE;
          else                state_d = PACK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = ((state_q == IDLE) || (state_q == PACK)) && !fifo_full;
  end

  // Buffer is cleared after every write so unfilled lanes of a short word are zero.
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    buf_d      = buf_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    len_d      = len_q;
    pd_d       = (state_q == DONE);
    first_d    = first_q;
    word       = buf_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_cnt_q == CNT_W'(i)) word[i*IN_WIDTH +: IN_WIDTH] = s_data;
    end
    if (accept) begin
      if (s_last || lane_last) begin
        din_d      = word;
        wr_en_d    = 1'b1;
        len_d      = first_q ? 32'd1 : len_q + 32'd1;
        first_d    = s_last;
        buf_d      = '0;
        lane_cnt_d = '0;
      end else begin
        buf_d      = word;
        lane_cnt_d = lane_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      lane_cnt_q <= '0;
      buf_q      <= '0;
      din_q      <= '0;
      wr_en_q    <= 1'b0;
      len_q      <= '0;
      pd_q       <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      buf_q      <= buf_d;
      din_q      <= din_d;
      wr_en_q    <= wr_en_d;
      len_q      <= len_d;
      pd_q       <= pd_d;
      first_q    <= first_d;
    end
  end

  assign din          = din_q;
  assign wr_en        = wr_en_q;
  assign data_len     = len_q;
  assign process_done = pd_q;

endmodule
